// File: rtl/iir_out_collector.sv
// Collects IIR filter results (ce_out/Out1), rounds and saturates them to the
// sample width, and queues them in a first-word fall-through FIFO drained over valid/ready.
module iir_out_collector #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 24,
  parameter int SHIFT = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ce_out,
  input  logic signed [IN_W-1:0]     Out1,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic        [OUT_W-1:0]    m_data,
  output logic        [$clog2(DEPTH):0] level,
  output logic                       overflow,
  output logic        [CNT_W-1:0]    sat_cnt,
  output logic        [CNT_W-1:0]    drop_cnt,
  input  logic                       clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic        [IN_W:0] ROUND   = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Handshake: a sample transfers on the rising edge where m_valid and m_ready are
  // both 1; m_data and m_valid are held while m_valid is 1 and m_ready is 0.

  logic signed [IN_W:0]  w_sum;
  logic signed [IN_W:0]  w_rnd;
  logic                  w_sat_hi;
  logic                  w_sat_lo;
  logic [OUT_W-1:0]      w_sat_data;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_sat_evt;

  logic                  r_s1_v;
  logic signed [IN_W:0]  r_s1_r;
  logic                  r_s2_v;
  logic [OUT_W-1:0]      r_s2_data;
  logic                  r_s2_sat;
  logic [OUT_W-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_sat_cnt;
  logic [CNT_W-1:0]      r_drop_cnt;

  // One extra bit of headroom so the rounding offset can never wrap the top value.
  assign w_sum = $signed({Out1[IN_W-1], Out1}) + $signed(ROUND);
  assign w_rnd = w_sum >>> SHIFT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_v <= 1'b0;
      r_s1_r <= '0;
    end else begin
      r_s1_v <= ce_out;
      if (ce_out) r_s1_r <= w_rnd;
    end
  end

  assign w_sat_hi = (r_s1_r > SAT_MAX);
  assign w_sat_lo = (r_s1_r < SAT_MIN);

  always_comb begin
    w_sat_data = r_s1_r[OUT_W-1:0];
    if (w_sat_hi)      w_sat_data = SAT_MAX[OUT_W-1:0];
    else if (w_sat_lo) w_sat_data = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_sat  <= 1'b0;
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_data <= w_sat_data;
        r_s2_sat  <= w_sat_hi | w_sat_lo;
      end
    end
  end

  // When full, a write is only accepted if the head is leaving in the same cycle.
  assign w_pop     = m_valid & m_ready;
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_push    = r_s2_v & (~w_full | w_pop);
  assign w_drop    = r_s2_v & w_full & ~w_pop;
  assign w_sat_evt = r_s2_v & r_s2_sat;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s2_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (clr_stats) begin
      r_overflow <= 1'b0;
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_drop && !(&r_drop_cnt))   r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      if (w_sat_evt && !(&r_sat_cnt)) r_sat_cnt  <= r_sat_cnt + CNT_W'(1);
    end
  end

  assign m_valid  = (r_level != '0);
  assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign sat_cnt  = r_sat_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_iir_out_collector.sv
// Bench for iir_out_collector: directed and random traffic checked each cycle
// against a queue-based reference of the round/saturate/FIFO rules.
module tb_iir_out_collector;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               ce_out = 1'b0;
  logic signed [39:0] Out1 = '0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic        [23:0] m_data;
  logic        [4:0]  level;
  logic               overflow;
  logic        [15:0] sat_cnt;
  logic        [15:0] drop_cnt;
  logic               clr_stats = 1'b0;

  iir_out_collector dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_out    (ce_out),
    .Out1      (Out1),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .level     (level),
    .overflow  (overflow),
    .sat_cnt   (sat_cnt),
    .drop_cnt  (drop_cnt),
    .clr_stats (clr_stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] val;
    bit          sat;
  } pend_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  pend_t       pipe_q[$];
  logic [23:0] exp_q[$];
  int          m_sat = 0;
  int          m_drop = 0;
  bit          m_ovf = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Reference: each accepted sample appears at the FIFO tail two edges later.
  task automatic model_edge(input bit ce, input logic signed [39:0] x, input bit rdy, input bit clr);
    longint r;
    bit     s;
    pend_t  p;
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (pipe_q.size() != 0 && pipe_q[0].due == cyc) begin
      p = pipe_q.pop_front();
      if (p.sat && m_sat < 65535) m_sat++;
      if (exp_q.size() < 16) exp_q.push_back(p.val);
      else begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1'b1;
      end
    end
    if (ce) begin
      r = (longint'(x) + 32768) >>> 16;
      s = 1'b0;
      if (r > 8388607) begin
        r = 8388607;
        s = 1'b1;
      end else if (r < -8388608) begin
        r = -8388608;
        s = 1'b1;
      end
      p.due = cyc + 2;
      p.val = 24'(r);
      p.sat = s;
      pipe_q.push_back(p);
    end
    if (clr) begin
      m_sat  = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    chk("level", 64'(level), 64'(exp_q.size()));
    chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
    chk("m_data", 64'($signed(m_data)), exp_q.size() != 0 ? 64'($signed(exp_q[0])) : 64'sd0);
    chk("sat_cnt", 64'(sat_cnt), 64'(m_sat));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic step(input bit ce, input logic signed [39:0] x, input bit rdy, input bit clr);
    ce_out    = ce;
    Out1      = x;
    m_ready   = rdy;
    clr_stats = clr;
    @(posedge clk);
    model_edge(ce, x, rdy, clr);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic signed [39:0] rand_x();
    case ($urandom_range(0, 3))
      0:       return 40'($signed($urandom) >>> 10);
      1:       return 40'(64'sh7F_FFFF_0000 + longint'($urandom_range(0, 65535)));
      2:       return 40'(-64'sh80_0000_0000 + longint'($urandom_range(0, 65535)));
      default: return 40'({$urandom, $urandom});
    endcase
  endfunction

  longint dir_v[11] = '{65536, 32768, 32767, -32768, -32769, -98304,
                        64'sh7F_FFFF_FFFF, -64'sh80_0000_0000,
                        64'sh7F_FFFF_8000, 64'sh7F_FFFF_7FFF, 0};

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // Rounding and saturation corner values, consumer always ready.
    for (int i = 0; i < 11; i++) step(1'b1, 40'(dir_v[i]), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Overfill with the consumer stalled, then drain in order.
    for (int i = 0; i < 17; i++) step(1'b1, 40'(longint'(i) <<< 16), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Refill, then write and pop together while full.
    for (int i = 0; i < 16; i++) step(1'b1, rand_x(), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, rand_x(), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, rand_x(), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);

    // Random traffic with occasional statistic clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, rand_x(), $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 8; i++) step(1'b1, 40'(longint'(i + 100) <<< 16), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && exp_q.size() > 5; k++) step(1'b0, '0, 1'b1, 1'b0);
    chk("pre_reset_level", 64'(level), 64'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_level", 64'(level), 64'd0);
    chk("async_rst_valid", 64'(m_valid), 64'd0);
    exp_q.delete();
    pipe_q.delete();
    m_sat  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
    ce_out  = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_outputs();
    step(1'b1, 40'sd196608, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
